ddr_responder: RTL and testbench



---
 rtl/ddr_responder.sv | 193 +++++++++++++++++++
 tb/tb_ddr_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_responder.sv
// ddr_responder: Avalon-MM burst responder backed by an on-chip word memory.
// It serves single and burst reads and writes, and supports byte-masked writes.
// It can inject wait-request backpressure and keeps a sticky protocol-error flag.
//
// Read timing: a read accepted at edge T updates the registered outputs on
// edges T+READ_LATENCY-1 ... T+READ_LATENCY+N-2. The consumer therefore samples
// valid beats on edges T+READ_LATENCY ... T+READ_LATENCY+N-1.
// waitReq is high from the cycle after T through the cycle carrying the last
// beat.
module ddr_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH_LOG2   = 12,
  parameter int BURST_WIDTH  = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_ddr_rd,
  input  logic                    io_ddr_wr,
  input  logic [ADDR_WIDTH-1:0]   io_ddr_addr,
  input  logic [BURST_WIDTH-1:0]  io_ddr_burstLength,
  input  logic [DATA_WIDTH/8-1:0] io_ddr_mask,
  input  logic [DATA_WIDTH-1:0]   io_ddr_din,
  output logic [DATA_WIDTH-1:0]   io_ddr_dout,
  output logic                    io_ddr_valid,
  output logic                    io_ddr_waitReq,
  input  logic                    io_stall,
  output logic                    io_error
);
  localparam int MW    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Issue-to-output pipeline stages (the output register is the final stage).
  localparam int PD    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic [DEPTH_LOG2-1:0]  nxt_q, nxt_d;
  logic                   err_q, err_d;
  logic [PD-1:0]          pv_q, pv_d, pl_q, pl_d;
  logic [PD-1:0][DEPTH_LOG2-1:0] pa_q, pa_d;
  logic                   vld_q, vld_d, last_q, last_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;

  logic                   wait_req, acc_wr, acc_rd;
  logic [DEPTH_LOG2-1:0]  addr_w, wa;
  logic [BURST_WIDTH-1:0] blen;
  logic                   we;
  logic                   iss_vld, iss_last;
  logic [DEPTH_LOG2-1:0]  iss_addr;
  logic                   feed_v, feed_l;
  logic [DEPTH_LOG2-1:0]  feed_a;

  // Byte-offset and aliased high address bits play no part in word selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{io_ddr_addr[ADDR_WIDTH-1:DEPTH_LOG2+3], io_ddr_addr[2:0]};

  assign io_ddr_waitReq = wait_req;
  assign io_ddr_valid   = vld_q;
  assign io_ddr_dout    = dout_q;
  assign io_error       = err_q;

  // Command decode, burst bookkeeping and read-beat issue.
  always_comb begin
    wait_req = io_stall | (state_q == S_READ);
    acc_wr   = io_ddr_wr & ~wait_req;
    acc_rd   = io_ddr_rd & ~wait_req;
    addr_w   = io_ddr_addr[DEPTH_LOG2+2:3];
    blen     = (io_ddr_burstLength == '0) ? BURST_WIDTH'(1) : io_ddr_burstLength;
    state_d  = state_q;
    rem_d    = rem_q;
    nxt_d    = nxt_q;
    err_d    = err_q;
    we       = 1'b0;
    wa       = addr_w;
    iss_vld  = 1'b0;
    iss_last = 1'b0;
    iss_addr = nxt_q;
    case (state_q)
      S_IDLE: begin
        if (acc_wr) begin
          // A write wins over a simultaneous read; the read is dropped.
          we = 1'b1;
          wa = addr_w;
          if (acc_rd) err_d = 1'b1;
          if (blen > BURST_WIDTH'(1)) begin
            state_d = S_WRITE;
            rem_d   = blen - BURST_WIDTH'(1);
            nxt_d   = addr_w + DEPTH_LOG2'(1);
          end
        end else if (acc_rd) begin
          iss_vld  = 1'b1;
          iss_addr = addr_w;
          iss_last = (blen == BURST_WIDTH'(1));
          rem_d    = blen - BURST_WIDTH'(1);
          nxt_d    = addr_w + DEPTH_LOG2'(1);
          state_d  = S_READ;
        end
      end
      S_WRITE: begin
        if (io_ddr_rd) err_d = 1'b1;
        if (acc_wr) begin
          we    = 1'b1;
          wa    = nxt_q;
          nxt_d = nxt_q + DEPTH_LOG2'(1);
          rem_d = rem_q - BURST_WIDTH'(1);
          if (rem_q == BURST_WIDTH'(1)) state_d = S_IDLE;
        end
      end
      S_READ: begin
        // One beat issued per cycle; stall never delays beats in flight.
        if (rem_q != '0) begin
          iss_vld  = 1'b1;
          iss_addr = nxt_q;
          iss_last = (rem_q == BURST_WIDTH'(1));
          nxt_d    = nxt_q + DEPTH_LOG2'(1);
          rem_d    = rem_q - BURST_WIDTH'(1);
        end
        // Leave once the last beat has spent its cycle on the output.
        if (vld_q && last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read pipeline shift and output-register next values.
  always_comb begin
    pv_d    = pv_q;
    pl_d    = pl_q;
    pa_d    = pa_q;
    pv_d[0] = iss_vld;
    pl_d[0] = iss_last;
    pa_d[0] = iss_addr;
    for (int i = 1; i < PD; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
    if (READ_LATENCY == 1) begin
      feed_v = iss_vld;
      feed_l = iss_last;
      feed_a = iss_addr;
    end else begin
      feed_v = pv_q[PD-1];
      feed_l = pl_q[PD-1];
      feed_a = pa_q[PD-1];
    end
    vld_d  = feed_v;
    last_d = feed_v & feed_l;
    dout_d = dout_q;
    if (feed_v) dout_d = mem[feed_a];
  end

  // FSM and control/output registers; reset abandons any burst in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      nxt_q   <= '0;
      err_q   <= 1'b0;
      pv_q    <= '0;
      pl_q    <= '0;
      pa_q    <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      nxt_q   <= nxt_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      pa_q    <= pa_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
    end
  end

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge clock) begin
    if (we && !reset) begin
      for (int b = 0; b < MW; b++) begin
        if (io_ddr_mask[b]) mem[wa][b*8 +: 8] <= io_ddr_din[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ddr_responder.sv
// Directed bench for ddr_responder: table of single write/read pairs plus
// hand-written burst, wrap, protocol-error and reset-mid-read sequences.
module tb_ddr_responder;
  localparam int L = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_ddr_rd, io_ddr_wr;
  logic [31:0] io_ddr_addr;
  logic [7:0]  io_ddr_burstLength;
  logic [7:0]  io_ddr_mask;
  logic [63:0] io_ddr_din;
  logic [63:0] io_ddr_dout;
  logic        io_ddr_valid, io_ddr_waitReq, io_stall, io_error;

  int n_cmp = 0;
  int n_bad = 0;

  ddr_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH_LOG2(12), .BURST_WIDTH(8), .READ_LATENCY(L)
  ) dut (
    .clock(clock), .reset(reset),
    .io_ddr_rd(io_ddr_rd), .io_ddr_wr(io_ddr_wr),
    .io_ddr_addr(io_ddr_addr), .io_ddr_burstLength(io_ddr_burstLength),
    .io_ddr_mask(io_ddr_mask), .io_ddr_din(io_ddr_din),
    .io_ddr_dout(io_ddr_dout), .io_ddr_valid(io_ddr_valid),
    .io_ddr_waitReq(io_ddr_waitReq), .io_stall(io_stall), .io_error(io_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [63:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Bounded wait until the responder can take a command.
  task automatic wait_ready();
    int k;
    k = 0;
    while (io_ddr_waitReq && k < 50) begin
      tick();
      k++;
    end
    if (io_ddr_waitReq) chk("ready_timeout", 64'(io_ddr_waitReq), 64'd0);
  endtask

  task automatic wr_single(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    wait_ready();
    io_ddr_addr = a; io_ddr_din = d; io_ddr_mask = m; io_ddr_burstLength = 8'd1;
    io_ddr_wr = 1'b1;
    tick();
    io_ddr_wr = 1'b0;
  endtask

  task automatic wr_burst(input logic [31:0] a, input int n, input logic [63:0] base);
    wait_ready();
    io_ddr_addr = a; io_ddr_mask = 8'hFF; io_ddr_burstLength = 8'(n);
    for (int i = 0; i < n; i++) begin
      io_ddr_din = base + 64'(i);
      io_ddr_wr  = 1'b1;
      tick();
    end
    io_ddr_wr = 1'b0;
  endtask

  // Issue one read and check waitReq/valid/dout cycle by cycle.
  task automatic rd_check(input string nm, input logic [31:0] a, input logic [7:0] bl,
                          input int n, input logic [63:0] e [8]);
    int b;
    wait_ready();
    io_ddr_addr = a; io_ddr_burstLength = bl; io_ddr_rd = 1'b1;
    tick();
    io_ddr_rd = 1'b0;
    b = 0;
    for (int k = 0; k <= L + n; k++) begin
      chk({nm, "_waitreq"}, 64'(io_ddr_waitReq), 64'(k <= L + n - 2));
      if (k >= L - 1 && k <= L + n - 2) begin
        chk({nm, "_valid"}, 64'(io_ddr_valid), 64'd1);
        chk({nm, "_data"}, io_ddr_dout, e[b]);
        b++;
      end else begin
        chk({nm, "_novalid"}, 64'(io_ddr_valid), 64'd0);
      end
      tick();
    end
  endtask

  initial begin
    vec_t        tbl [6];
    logic [63:0] e [8];

    tbl[0] = '{32'h0000_0040, 32'h0000_0040, 64'h1122334455667788, 8'hFF, 64'h1122334455667788};
    tbl[1] = '{32'h0000_0000, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 64'h0, 8'h0F, 64'hFFFF_FFFF_0000_0000};
    tbl[3] = '{32'h0000_0040, 32'h0000_0040, 64'hAAAA_AAAA_AAAA_AAAA, 8'h81, 64'hAA22_3344_5566_77AA};
    tbl[4] = '{32'h8000_0040, 32'h0000_0040, 64'h0, 8'h00, 64'hAA22_3344_5566_77AA};
    tbl[5] = '{32'h0001_0048, 32'h0000_0048, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF};

    reset = 1'b1; io_ddr_rd = 1'b0; io_ddr_wr = 1'b0; io_ddr_addr = '0;
    io_ddr_burstLength = 8'd1; io_ddr_mask = '0; io_ddr_din = '0; io_stall = 1'b1;
    tick(); tick();
    chk("rst_valid", 64'(io_ddr_valid), 64'd0);
    chk("rst_dout", io_ddr_dout, 64'd0);
    chk("rst_error", 64'(io_error), 64'd0);
    chk("rst_wait_stall1", 64'(io_ddr_waitReq), 64'd1);
    io_stall = 1'b0; #1;
    chk("rst_wait_stall0", 64'(io_ddr_waitReq), 64'd0);
    reset = 1'b0;
    tick();

    // Single write then single read per table entry.
    for (int i = 0; i < 6; i++) begin
      wr_single(tbl[i].waddr, tbl[i].data, tbl[i].mask);
      e[0] = tbl[i].exp;
      rd_check($sformatf("vec%0d", i), tbl[i].raddr, 8'd1, 1, e);
    end

    // Burst of 4 at word DEPTH-2 with a gap and two stall cycles; wraps to 0.
    wait_ready();
    io_ddr_addr = 32'h0000_7FF0; io_ddr_mask = 8'hFF; io_ddr_burstLength = 8'd4;
    io_ddr_wr = 1'b1; io_ddr_din = 64'd1; tick();
    io_ddr_din = 64'd2; tick();
    io_ddr_wr = 1'b0; tick();
    io_ddr_wr = 1'b1; io_ddr_din = 64'd3; io_stall = 1'b1; #1;
    chk("stall_waitreq", 64'(io_ddr_waitReq), 64'd1);
    tick(); tick();
    io_stall = 1'b0; tick();
    io_ddr_din = 64'd4; tick();
    io_ddr_wr = 1'b0;
    e[0] = 64'd1; e[1] = 64'd2; e[2] = 64'd3; e[3] = 64'd4;
    rd_check("wrap_burst", 32'h0000_7FF0, 8'd4, 4, e);
    e[0] = 64'd3;
    rd_check("wrap_w0", 32'h0000_0000, 8'd1, 1, e);
    e[0] = 64'd4;
    rd_check("wrap_w1", 32'h0000_0008, 8'd1, 1, e);

    // Burst length 0 behaves as a single beat.
    e[0] = 64'hAA22_3344_5566_77AA;
    rd_check("blen0", 32'h0000_0040, 8'd0, 1, e);

    // rd and wr together in IDLE: write wins, no read beats, sticky error.
    chk("err_before", 64'(io_error), 64'd0);
    io_ddr_addr = 32'h0000_0100; io_ddr_din = 64'h5A5A_5A5A_5A5A_5A5A; io_ddr_mask = 8'hFF;
    io_ddr_burstLength = 8'd1; io_ddr_rd = 1'b1; io_ddr_wr = 1'b1;
    tick();
    io_ddr_rd = 1'b0; io_ddr_wr = 1'b0;
    for (int k = 0; k < L + 2; k++) begin
      chk("collide_novalid", 64'(io_ddr_valid), 64'd0);
      chk("collide_nowait", 64'(io_ddr_waitReq), 64'd0);
      tick();
    end
    chk("collide_error", 64'(io_error), 64'd1);
    e[0] = 64'h5A5A_5A5A_5A5A_5A5A;
    rd_check("collide_wdata", 32'h0000_0100, 8'd1, 1, e);
    chk("error_sticky", 64'(io_error), 64'd1);

    // Reset after the 3rd beat of an 8-beat read.
    wr_burst(32'h0000_0400, 8, 64'h100);
    wait_ready();
    io_ddr_addr = 32'h0000_0400; io_ddr_burstLength = 8'd8; io_ddr_rd = 1'b1;
    tick();
    io_ddr_rd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rstrd_valid", 64'(io_ddr_valid), 64'(k >= L - 1));
      if (k >= L - 1) chk("rstrd_data", io_ddr_dout, 64'h100 + 64'(k - (L - 1)));
      if (k == L + 1) reset = 1'b1;
      tick();
    end
    chk("rstrd_valid_off", 64'(io_ddr_valid), 64'd0);
    chk("rstrd_dout", io_ddr_dout, 64'd0);
    chk("rstrd_error", 64'(io_error), 64'd0);
    chk("rstrd_wait0", 64'(io_ddr_waitReq), 64'd0);
    io_stall = 1'b1; #1;
    chk("rstrd_wait1", 64'(io_ddr_waitReq), 64'd1);
    io_stall = 1'b0;
    reset = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("rstrd_quiet", 64'(io_ddr_valid), 64'd0);
      tick();
    end
    for (int i = 0; i < 8; i++) e[i] = 64'h100 + 64'(i);
    rd_check("rstrd_reread", 32'h0000_0400, 8'd8, 8, e);

    // rd during a write burst is ignored but flagged; the burst completes.
    wait_ready();
    io_ddr_addr = 32'h0000_0200; io_ddr_mask = 8'hFF; io_ddr_burstLength = 8'd2;
    io_ddr_din = 64'hC0DE_0000_0000_0001; io_ddr_wr = 1'b1;
    tick();
    io_ddr_din = 64'hC0DE_0000_0000_0002; io_ddr_rd = 1'b1;
    tick();
    io_ddr_rd = 1'b0; io_ddr_wr = 1'b0;
    chk("wrrd_error", 64'(io_error), 64'd1);
    chk("wrrd_novalid", 64'(io_ddr_valid), 64'd0);
    e[0] = 64'hC0DE_0000_0000_0001; e[1] = 64'hC0DE_0000_0000_0002;
    rd_check("wrrd_data", 32'h0000_0200, 8'd2, 2, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
